// File: rtl/sts_event_counter.sv
// Multi-channel event counter with manual/periodic snapshots into a status register bus.
// Live counters saturate with sticky overflow; snapshots carry a 16-bit sequence number.
module sts_event_counter #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [CHANNELS-1:0]               evt_in,
  input  logic                              snap_req,
  input  logic                              clr_req,
  input  logic [31:0]                       snap_period,
  output logic [32+CHANNELS*CNT_WIDTH-1:0]  sts_data,
  output logic                              snap_done
);

  localparam int CW = CNT_WIDTH;
  localparam int NW = CHANNELS * CNT_WIDTH;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CHANNELS-1:0] sync1, sync2, hist, evt_pulse;
  logic                snap_q, clr_q, snap_edge, clr_edge;
  logic                auto_snap, do_snap;
  logic [31:0]         timer;
  logic [NW-1:0]       cnt_q, cnt_inc, snap_cnt;
  logic [CHANNELS-1:0] ovf_q, ovf_inc, snap_ovf;
  logic [15:0]         seq;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= evt_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign evt_pulse = sync2 & ~hist;

  // Edge flops come out of reset high, so a request held across release must drop first.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      snap_q <= 1'b1;
      clr_q  <= 1'b1;
    end else begin
      snap_q <= snap_req;
      clr_q  <= clr_req;
    end
  end

  assign snap_edge = snap_req & ~snap_q;
  assign clr_edge  = clr_req & ~clr_q;

  assign auto_snap = (snap_period != 32'd0) && (timer >= (snap_period - 32'd1));
  assign do_snap   = snap_edge | auto_snap;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      timer <= '0;
    end else if (snap_period == 32'd0 || auto_snap) begin
      timer <= '0;
    end else begin
      timer <= timer + 32'd1;
    end
  end

  always_comb begin
    cnt_inc = cnt_q;
    ovf_inc = ovf_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (evt_pulse[i]) begin
        if (&cnt_q[i*CW +: CW]) begin
          ovf_inc[i] = 1'b1;
        end else begin
          cnt_inc[i*CW +: CW] = cnt_q[i*CW +: CW] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn || clr_edge) begin
      cnt_q <= '0;
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_inc;
      ovf_q <= ovf_inc;
    end
  end

  // Snapshot sees the same-cycle increment and the pre-clear values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      snap_cnt  <= '0;
      snap_ovf  <= '0;
      seq       <= '0;
      snap_done <= 1'b0;
    end else begin
      snap_done <= do_snap;
      if (do_snap) begin
        snap_cnt <= cnt_inc;
        snap_ovf <= ovf_inc;
        seq      <= seq + 16'd1;
      end
    end
  end

  always_comb begin
    sts_data = '0;
    sts_data[15:0]          = seq;
    sts_data[16 +: CHANNELS] = snap_ovf;
    sts_data[32 +: NW]       = snap_cnt;
  end

endmodule
